// File: rtl/bus_trace.sv
// Z80 bus trace recorder: turns completed CPU accesses into typed records in a
// circular buffer, freezes a fixed number of records after a trigger, drains oldest-first.
module bus_trace #(
    parameter  int ADDR_W     = 16,
    parameter  int DATA_W     = 8,
    parameter  int DEPTH      = 256,
    parameter  int POST_COUNT = 128,
    localparam int RECORD_W   = 3 + ADDR_W + DATA_W,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_ce,
    input  logic                nM1,
    input  logic                nMREQ,
    input  logic                nIORQ,
    input  logic                nRD,
    input  logic                nWR,
    input  logic                nRFSH,
    input  logic [ADDR_W-1:0]   A,
    input  logic [DATA_W-1:0]   D,
    input  logic                arm,
    input  logic [1:0]          trig_mode,
    input  logic [ADDR_W-1:0]   trig_addr,
    input  logic [ADDR_W-1:0]   trig_mask,
    input  logic                rd_en,
    output logic [RECORD_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                empty,
    output logic [1:0]          state,
    output logic                triggered,
    output logic [CNT_W-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        POST  = 2'b10,
        DONE  = 2'b11
    } fsm_t;

    fsm_t fsm, fsmNext;

    logic                pM1, pMREQ, pIORQ, pRD, pWR, pRFSH;
    logic [ADDR_W-1:0]   pA;
    logic [DATA_W-1:0]   pD;
    logic [PTR_W-1:0]    wrPtr;
    logic [PTR_W-1:0]    rdPtr;
    logic [CNT_W-1:0]    postCnt;
    logic [RECORD_W-1:0] mem [DEPTH];

    logic       actNow, prevAct, recEvent;
    logic [2:0] recType;
    logic       addrHit, typeHit, match;
    logic       doWrite, doPop;

    assign actNow   = (!nMREQ | !nIORQ) & (!nRD | !nWR) & nRFSH;
    assign prevAct  = (!pMREQ | !pIORQ) & (!pRD | !pWR) & pRFSH;
    assign recEvent = cpu_ce & prevAct & !actNow;

    always_comb begin
        recType = 3'd4;
        if (!pRD && !pWR)
            recType = 3'd7;
        else if (!pMREQ) begin
            if (!pM1 && !pRD)
                recType = 3'd0;
            else if (!pRD)
                recType = 3'd1;
            else
                recType = 3'd2;
        end else if (!pRD)
            recType = 3'd3;
    end

    assign addrHit = (pA & trig_mask) == (trig_addr & trig_mask);

    always_comb begin
        typeHit = 1'b0;
        case (trig_mode)
            2'b00: typeHit = 1'b1;
            2'b01: typeHit = (recType == 3'd0);
            2'b10: typeHit = (recType == 3'd2);
            2'b11: typeHit = (recType == 3'd3) || (recType == 3'd4);
            default: typeHit = 1'b0;
        endcase
    end

    assign match = addrHit & typeHit;

    // Writes are contiguous from slot 0 after arm, so the oldest unread record
    // is always wrPtr - count (mod DEPTH); no separate read pointer is kept.
    assign rdPtr = wrPtr - count[PTR_W-1:0];
    assign empty = (count == '0) | (fsm != DONE);
    assign state = fsm;

    always_comb begin
        fsmNext = fsm;
        doWrite = 1'b0;
        doPop   = 1'b0;
        if (arm)
            fsmNext = ARMED;
        else begin
            case (fsm)
                IDLE: ;
                ARMED: begin
                    doWrite = recEvent;
                    if (recEvent && match)
                        fsmNext = (POST_COUNT == 1) ? DONE : POST;
                end
                POST: begin
                    doWrite = recEvent;
                    if (recEvent && postCnt == POST_LAST)
                        fsmNext = DONE;
                end
                DONE: begin
                    doPop = rd_en && (count != '0);
                    if (doPop && count == CNT_W'(1))
                        fsmNext = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            wrPtr     <= '0;
            count     <= '0;
            postCnt   <= '0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            pM1       <= 1'b1;
            pMREQ     <= 1'b1;
            pIORQ     <= 1'b1;
            pRD       <= 1'b1;
            pWR       <= 1'b1;
            pRFSH     <= 1'b1;
            pA        <= '0;
            pD        <= '0;
        end else begin
            fsm      <= fsmNext;
            rd_valid <= doPop;
            if (cpu_ce) begin
                pM1   <= nM1;
                pMREQ <= nMREQ;
                pIORQ <= nIORQ;
                pRD   <= nRD;
                pWR   <= nWR;
                pRFSH <= nRFSH;
                pA    <= A;
                pD    <= D;
            end
            if (arm) begin
                wrPtr     <= '0;
                count     <= '0;
                postCnt   <= '0;
                triggered <= 1'b0;
            end else begin
                if (doWrite) begin
                    wrPtr <= wrPtr + 1'b1;
                    if (count != FULL)
                        count <= count + 1'b1;
                    if (fsm == ARMED && match) begin
                        triggered <= 1'b1;
                        postCnt   <= CNT_W'(1);
                    end else if (fsm == POST)
                        postCnt <= postCnt + 1'b1;
                end
                if (doPop) begin
                    count   <= count - 1'b1;
                    rd_data <= mem[rdPtr];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite)
            mem[wrPtr] <= {recType, pA, pD};
    end

endmodule

// File: tb/tb_bus_trace.sv
// Directed bench for bus_trace with DEPTH=4, POST_COUNT=2: record typing and
// trigger modes from a vector table, then capture/wrap/refresh/re-arm/reset sequences.
module tb_bus_trace;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ARMED = 2'b01;
    localparam logic [1:0] S_POST  = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic        clk = 1'b0;
    logic        reset, cpu_ce;
    logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
    logic [15:0] A, trig_addr, trig_mask;
    logic [7:0]  D;
    logic        arm, rd_en;
    logic [1:0]  trig_mode;
    logic [26:0] rd_data;
    logic        rd_valid, empty, triggered;
    logic [1:0]  state;
    logic [2:0]  count;

    bus_trace #(.ADDR_W(16), .DATA_W(8), .DEPTH(4), .POST_COUNT(2)) dut (
        .clk(clk), .reset(reset), .cpu_ce(cpu_ce),
        .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH),
        .A(A), .D(D), .arm(arm), .trig_mode(trig_mode),
        .trig_addr(trig_addr), .trig_mask(trig_mask), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .state(state), .triggered(triggered), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        m1, mreq, iorq, rd, wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] tAddr, tMask;
        logic [1:0]  mode;
        logic [2:0]  typ;
        logic        match;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] rec(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d);
        return {5'b0, t, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ceTick();
        cpu_ce = 1'b1;
        tick();
        cpu_ce = 1'b0;
        tick();
    endtask

    task automatic setBus(input logic m1, mreq, iorq, rd, wr, rfsh,
                          input logic [15:0] a, input logic [7:0] d);
        nM1 = m1; nMREQ = mreq; nIORQ = iorq; nRD = rd; nWR = wr; nRFSH = rfsh;
        A = a; D = d;
    endtask

    task automatic idleBus();
        nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
    endtask

    // Two active samples, then a release sample that produces the record.
    task automatic access(input logic m1, mreq, iorq, rd, wr,
                          input logic [15:0] a, input logic [7:0] d);
        setBus(m1, mreq, iorq, rd, wr, 1'b1, a, d);
        ceTick();
        ceTick();
        idleBus();
        ceTick();
    endtask

    task automatic doArm(input logic [1:0] mode, input logic [15:0] ta, input logic [15:0] tm);
        trig_mode = mode; trig_addr = ta; trig_mask = tm;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic popOne(input string name, input logic [31:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        check({name, "_data"}, {5'b0, rd_data}, exp);
    endtask

    initial begin
        reset = 1'b1; cpu_ce = 1'b0; arm = 1'b0; rd_en = 1'b0;
        trig_mode = 2'b00; trig_addr = '0; trig_mask = '0;
        A = '0; D = '0;
        idleBus();
        tick();
        tick();
        reset = 1'b0;
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_trig", 32'(triggered), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", {5'b0, rd_data}, 32'd0);

        // Record typing and trigger-mode table
        vecs[0] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 16'h1234, 8'h5A, 16'h1234, 16'hFFFF, 2'b01, 3'd0, 1'b1};
        vecs[1] = '{1'b1,1'b0,1'b1,1'b0,1'b1, 16'h2001, 8'h11, 16'h2001, 16'hFFFF, 2'b01, 3'd1, 1'b0};
        vecs[2] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 16'h3002, 8'h22, 16'h3002, 16'hFFFF, 2'b10, 3'd2, 1'b1};
        vecs[3] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 16'h0044, 8'h33, 16'h0044, 16'hFFFF, 2'b11, 3'd3, 1'b1};
        vecs[4] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 16'h0055, 8'h44, 16'h0055, 16'hFFFF, 2'b10, 3'd4, 1'b0};
        vecs[5] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 16'h6006, 8'h66, 16'h6006, 16'hFFFF, 2'b00, 3'd7, 1'b1};
        vecs[6] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 16'h0077, 8'h77, 16'h0077, 16'hFFFF, 2'b11, 3'd4, 1'b1};
        vecs[7] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 16'h0088, 8'h88, 16'h0088, 16'hFFFF, 2'b10, 3'd0, 1'b0};
        vecs[8] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 16'h0120, 8'h99, 16'h0100, 16'hFF00, 2'b10, 3'd2, 1'b1};
        vecs[9] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 16'h0220, 8'hAA, 16'h0100, 16'hFF00, 2'b10, 3'd2, 1'b0};

        for (int i = 0; i < 10; i++) begin
            doArm(vecs[i].mode, vecs[i].tAddr, vecs[i].tMask);
            access(vecs[i].m1, vecs[i].mreq, vecs[i].iorq, vecs[i].rd, vecs[i].wr,
                   vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d_state", i), 32'(state),
                  32'(vecs[i].match ? S_POST : S_ARMED));
            trig_mode = 2'b00; trig_mask = '0;
            access(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 8'h00);
            if (!vecs[i].match)
                access(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 8'h00);
            check($sformatf("vec%0d_done", i), 32'(state), 32'(S_DONE));
            check($sformatf("vec%0d_count", i), 32'(count), vecs[i].match ? 32'd2 : 32'd3);
            popOne($sformatf("vec%0d_pop", i), rec(vecs[i].typ, vecs[i].addr, vecs[i].data));
        end

        // Basic capture: three writes, trigger on the middle one
        doArm(2'b10, 16'h0011, 16'hFFFF);
        access(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 8'hA1);
        check("capA_armed", 32'(state), 32'(S_ARMED));
        access(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0011, 8'hA2);
        check("capA_post", 32'(state), 32'(S_POST));
        check("capA_trig", 32'(triggered), 32'd1);
        access(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0012, 8'hA3);
        check("capA_done", 32'(state), 32'(S_DONE));
        check("capA_count", 32'(count), 32'd3);
        check("capA_nempty", 32'(empty), 32'd0);
        rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("capA_pvalid", 32'(rd_valid), 32'd1);
            check("capA_pdata", {5'b0, rd_data}, rec(3'd2, 16'(16'h0010 + k), 8'(8'hA1 + k)));
        end
        rd_en = 1'b0;
        check("capA_empty", 32'(empty), 32'd1);
        check("capA_idle", 32'(state), 32'(S_IDLE));
        check("capA_cnt0", 32'(count), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("drained_valid", 32'(rd_valid), 32'd0);
        check("drained_count", 32'(count), 32'd0);
        check("drained_hold", {5'b0, rd_data}, rec(3'd2, 16'h0012, 8'hA3));

        // Wrap: 10 IO reads, trigger at 7, keeps 5..8 oldest-first
        doArm(2'b11, 16'h0007, 16'hFFFF);
        for (int i = 0; i < 10; i++)
            access(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'(i), 8'(8'h30 + i));
        check("wrap_done", 32'(state), 32'(S_DONE));
        check("wrap_count", 32'(count), 32'd4);
        check("wrap_trig", 32'(triggered), 32'd1);
        rd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("wrap_pvalid", 32'(rd_valid), 32'd1);
            check("wrap_pdata", {5'b0, rd_data}, rec(3'd3, 16'(5 + k), 8'(8'h35 + k)));
        end
        rd_en = 1'b0;
        check("wrap_idle", 32'(state), 32'(S_IDLE));

        // M1 fetch running straight into refresh: only the fetch is recorded
        doArm(2'b00, 16'h0000, 16'h0000);
        setBus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'hC3);
        ceTick();
        ceTick();
        setBus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0055, 8'hEE);
        ceTick();
        ceTick();
        idleBus();
        ceTick();
        check("rfsh_count", 32'(count), 32'd1);
        check("rfsh_post", 32'(state), 32'(S_POST));
        access(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0042, 8'h5B);
        check("rfsh_done", 32'(state), 32'(S_DONE));
        popOne("rfsh_pop0", rec(3'd0, 16'h0000, 8'hC3));
        popOne("rfsh_pop1", rec(3'd1, 16'h0042, 8'h5B));

        // Re-arm in POST, ignored reads while capturing, then re-trigger
        doArm(2'b10, 16'h0011, 16'hFFFF);
        access(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 8'hA1);
        access(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0011, 8'hA2);
        check("rearm_pre", 32'(state), 32'(S_POST));
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("rearm_trig", 32'(triggered), 32'd0);
        check("rearm_count", 32'(count), 32'd0);
        check("rearm_state", 32'(state), 32'(S_ARMED));
        access(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 8'hA1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("armrd_valid", 32'(rd_valid), 32'd0);
        check("armrd_count", 32'(count), 32'd1);
        access(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0011, 8'hA2);
        check("retrig_trig", 32'(triggered), 32'd1);
        check("retrig_state", 32'(state), 32'(S_POST));
        access(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0012, 8'hA3);
        check("retrig_count", 32'(count), 32'd3);
        popOne("retrig_pop", rec(3'd2, 16'h0010, 8'hA1));
        tick();
        check("pulse_valid", 32'(rd_valid), 32'd0);
        check("pulse_hold", {5'b0, rd_data}, rec(3'd2, 16'h0010, 8'hA1));

        // Synchronous reset in DONE right after a pop
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("dreset_state", 32'(state), 32'(S_IDLE));
        check("dreset_count", 32'(count), 32'd0);
        check("dreset_empty", 32'(empty), 32'd1);
        check("dreset_valid", 32'(rd_valid), 32'd0);
        check("dreset_data", {5'b0, rd_data}, 32'd0);
        check("dreset_trig", 32'(triggered), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
